tcp_tx_rt_timer: RTL and testbench

Per-flow retransmission timer for the TCP transmit path. Arms a timer when the send engine emits data on a flow and disarms it when an incoming ACK covers all outstanding bytes. A partial-progress ACK restarts the timer. A round-robin scanner raises a retransmit request when a flow's timer expires. Sits between the TX send engine (arm), the RX ACK processing path (ack), and the TX retransmit scheduler (request).

---
 rtl/tcp_tx_rt_timer.sv | 158 +++++++++++++++
 tb/tb_tcp_tx_rt_timer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_rt_timer.sv
// tcp_tx_rt_timer: per-flow TCP retransmission timer.
//   Arm port (arm_*): the send engine reports the new end of outstanding data on a flow.
//   ACK port (ack_*): the cumulative ACK clears or restarts the flow's timer.
//   Request port (rt_req_*): a round-robin scanner raises one expired flow at a time.
// The per-flow state has a single write port. The arm path yields to an ACK in the
// same cycle. The flow being emitted is locked against arm and ACK until its request
// is accepted.
module tcp_tx_rt_timer #(
    parameter int unsigned MAX_FLOWS         = 8,
    parameter int unsigned FLOWID_W          = $clog2(MAX_FLOWS),
    parameter int unsigned TIMESTAMP_W       = 64,
    parameter int unsigned SEQ_NUM_W         = 32,
    parameter int unsigned RT_TIMEOUT_CYCLES = 250000000
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 arm_val,
    input  logic [FLOWID_W-1:0]  arm_flowid,
    input  logic [SEQ_NUM_W-1:0] arm_end_seq,
    output logic                 arm_rdy,

    input  logic                 ack_val,
    input  logic [FLOWID_W-1:0]  ack_flowid,
    input  logic [SEQ_NUM_W-1:0] ack_num,
    output logic                 ack_rdy,

    output logic                 rt_req_val,
    output logic [FLOWID_W-1:0]  rt_req_flowid,
    output logic [SEQ_NUM_W-1:0] rt_req_seq,
    input  logic                 rt_req_rdy
);

    typedef enum logic {
        SCAN = 1'b0,
        EMIT = 1'b1
    } scan_state_t;

    logic [MAX_FLOWS-1:0]   armed;
    logic [TIMESTAMP_W-1:0] timestamp [MAX_FLOWS];
    logic [SEQ_NUM_W-1:0]   end_seq   [MAX_FLOWS];
    logic [SEQ_NUM_W-1:0]   last_ack  [MAX_FLOWS];
    logic [TIMESTAMP_W-1:0] now;
    logic [FLOWID_W-1:0]    ptr;
    scan_state_t            state;

    logic                   emitting;
    logic                   arm_hs;
    logic                   ack_hs;
    logic                   emit_hs;
    logic                   ack_ge_end;
    logic                   ack_ge_last;
    logic                   expired;
    logic [FLOWID_W-1:0]    next_ptr;

    // Wrap-safe sequence compare: a is at or after b within half the number space.
    function automatic logic seq_ge(input logic [SEQ_NUM_W-1:0] a,
                                    input logic [SEQ_NUM_W-1:0] b);
        logic [SEQ_NUM_W-1:0] diff;
        diff = a - b;
        return ~diff[SEQ_NUM_W-1];
    endfunction

    // Handshake readiness: ACK owns the write port; the emitting flow is locked.
    assign emitting = (state == EMIT);
    assign ack_rdy  = rst_n & ~(emitting & (ack_flowid == rt_req_flowid));
    assign arm_rdy  = rst_n & ~ack_val & ~(emitting & (arm_flowid == rt_req_flowid));
    assign ack_hs   = ack_val & ack_rdy;
    assign arm_hs   = arm_val & arm_rdy;
    assign emit_hs  = emitting & rt_req_rdy;

    assign ack_ge_end  = seq_ge(ack_num, end_seq[ack_flowid]);
    assign ack_ge_last = seq_ge(ack_num, last_ack[ack_flowid]);

    // Elapsed time is unsigned modulo the counter width, so counter wrap is harmless.
    assign expired  = armed[ptr] &&
                      ((now - timestamp[ptr]) >= TIMESTAMP_W'(RT_TIMEOUT_CYCLES));
    assign next_ptr = (ptr == FLOWID_W'(MAX_FLOWS - 1)) ? '0 : ptr + FLOWID_W'(1);

    // Per-flow timer state and the free-running cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now   <= '0;
            armed <= '0;
            for (int i = 0; i < MAX_FLOWS; i++) begin
                timestamp[i] <= '0;
                end_seq[i]   <= '0;
                last_ack[i]  <= '0;
            end
        end else begin
            now <= now + TIMESTAMP_W'(1);

            if (ack_hs) begin
                if (ack_ge_end) begin
                    armed[ack_flowid] <= 1'b0;
                end else if (armed[ack_flowid] && (ack_num != last_ack[ack_flowid])
                             && ack_ge_last) begin
                    // Forward progress without full coverage restarts the timer.
                    timestamp[ack_flowid] <= now;
                end
                if (ack_ge_last) begin
                    last_ack[ack_flowid] <= ack_num;
                end
            end

            if (arm_hs) begin
                // Re-arming an active flow only extends coverage; the oldest
                // unacknowledged byte still sets the deadline.
                if (!armed[arm_flowid]) begin
                    armed[arm_flowid]     <= 1'b1;
                    timestamp[arm_flowid] <= now;
                end
                end_seq[arm_flowid] <= arm_end_seq;
            end

            // An accepted request restarts the period; the flow stays armed.
            if (emit_hs) begin
                timestamp[rt_req_flowid] <= now;
            end
        end
    end

    // Round-robin expiry scanner with a registered request port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= SCAN;
            ptr           <= '0;
            rt_req_val    <= 1'b0;
            rt_req_flowid <= '0;
            rt_req_seq    <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (expired) begin
                        rt_req_val    <= 1'b1;
                        rt_req_flowid <= ptr;
                        rt_req_seq    <= last_ack[ptr];
                        state         <= EMIT;
                    end else begin
                        ptr <= next_ptr;
                    end
                end
                EMIT: begin
                    if (rt_req_rdy) begin
                        rt_req_val <= 1'b0;
                        ptr        <= next_ptr;
                        state      <= SCAN;
                    end
                end
                default: begin
                    rt_req_val <= 1'b0;
                    state      <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx_rt_timer.sv
// tb_tcp_tx_rt_timer: scoreboard bench for tcp_tx_rt_timer.
// A reference model tracks per-flow timers as plain numbers and queues an expected
// request whenever a flow's elapsed time reaches the timeout. A monitor matches each
// presented request against that queue and checks its flow, sequence number and
// detection latency.
module tb_tcp_tx_rt_timer;

    localparam int unsigned MAX_FLOWS = 8;
    localparam int unsigned FLOWID_W  = 3;
    localparam int unsigned TS_W      = 64;
    localparam int unsigned SEQ_W     = 32;
    localparam int unsigned TIMEOUT   = 100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm_val = 1'b0;
    logic [2:0]       arm_flowid = '0;
    logic [31:0]      arm_end_seq = '0;
    logic             arm_rdy;
    logic             ack_val = 1'b0;
    logic [2:0]       ack_flowid = '0;
    logic [31:0]      ack_num = '0;
    logic             ack_rdy;
    logic             rt_req_val;
    logic [2:0]       rt_req_flowid;
    logic [31:0]      rt_req_seq;
    logic             rt_req_rdy = 1'b0;

    tcp_tx_rt_timer #(
        .MAX_FLOWS(MAX_FLOWS), .FLOWID_W(FLOWID_W), .TIMESTAMP_W(TS_W),
        .SEQ_NUM_W(SEQ_W), .RT_TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arm_val(arm_val), .arm_flowid(arm_flowid), .arm_end_seq(arm_end_seq),
        .arm_rdy(arm_rdy),
        .ack_val(ack_val), .ack_flowid(ack_flowid), .ack_num(ack_num), .ack_rdy(ack_rdy),
        .rt_req_val(rt_req_val), .rt_req_flowid(rt_req_flowid), .rt_req_seq(rt_req_seq),
        .rt_req_rdy(rt_req_rdy)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        int unsigned     fid;
        logic [31:0]     seq;
        longint unsigned exp_now;
    } exp_t;

    exp_t            exp_q[$];
    bit              m_armed [MAX_FLOWS];
    longint unsigned m_ts    [MAX_FLOWS];
    logic [31:0]     m_end   [MAX_FLOWS];
    logic [31:0]     m_last  [MAX_FLOWS];
    longint unsigned m_now = 0;
    bit              mvalid = 1'b0;
    bit              m_rst_prev = 1'b0;

    bit              prev_val = 1'b0;
    bit              prev_rdy = 1'b0;
    logic [2:0]      prev_fid = '0;
    logic [31:0]     prev_seq = '0;
    int unsigned     req_count = 0;
    longint unsigned last_req_now = 0;
    logic [2:0]      last_req_fid = '0;
    logic [31:0]     last_req_seq = '0;
    longint unsigned lat_bound = MAX_FLOWS;
    int unsigned     rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input longint val);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: observed value %0d is outside the expected range", name, val);
        end
    endtask

    // Number-space rule: a is at or after b when (a - b) mod 2^32 is below 2^31.
    function automatic bit m_seq_ge(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        return d < 32'h8000_0000;
    endfunction

    // Reference model, readiness checks and request monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        bit exp_ack_rdy;
        bit exp_arm_rdy;
        int idx;
        longint lat;

        exp_ack_rdy = rst_n && !(rt_req_val === 1'b1 && ack_flowid == rt_req_flowid);
        exp_arm_rdy = rst_n && !ack_val && !(rt_req_val === 1'b1 && arm_flowid == rt_req_flowid);
        if (mvalid && (ack_val || !rst_n)) check("ack_rdy", 64'(ack_rdy), 64'(exp_ack_rdy));
        if (mvalid && (arm_val || !rst_n)) check("arm_rdy", 64'(arm_rdy), 64'(exp_arm_rdy));

        if (mvalid && m_rst_prev) begin
            check("reset_req_val", 64'(rt_req_val), 64'd0);
            check("reset_req_fid", 64'(rt_req_flowid), 64'd0);
            check("reset_req_seq", 64'(rt_req_seq), 64'd0);
        end else if (mvalid) begin
            if (prev_val && prev_rdy) begin
                check("val_low_after_accept", 64'(rt_req_val), 64'd0);
            end else if (prev_val) begin
                check("hold_val", 64'(rt_req_val), 64'd1);
                check("hold_fid", 64'(rt_req_flowid), 64'(prev_fid));
                check("hold_seq", 64'(rt_req_seq), 64'(prev_seq));
            end else if (rt_req_val === 1'b1) begin
                req_count++;
                last_req_now = m_now;
                last_req_fid = rt_req_flowid;
                last_req_seq = rt_req_seq;
                idx = -1;
                foreach (exp_q[i]) begin
                    if (idx < 0 && exp_q[i].fid == 32'(rt_req_flowid)) idx = i;
                end
                check_true("req_expected_flow", idx >= 0, longint'(rt_req_flowid));
                if (idx >= 0) begin
                    check("req_seq", 64'(rt_req_seq), 64'(exp_q[idx].seq));
                    lat = longint'(m_now - exp_q[idx].exp_now);
                    check_true("req_latency", lat >= 1 && lat <= longint'(lat_bound), lat);
                    exp_q.delete(idx);
                end
            end
        end

        prev_val = (rt_req_val === 1'b1) && rst_n;
        prev_rdy = rt_req_rdy;
        prev_fid = rt_req_flowid;
        prev_seq = rt_req_seq;

        if (!rst_n) begin
            for (int f = 0; f < MAX_FLOWS; f++) begin
                m_armed[f] = 1'b0;
                m_ts[f]    = 0;
                m_end[f]   = '0;
                m_last[f]  = '0;
            end
            m_now = 0;
            exp_q.delete();
        end else if (mvalid) begin
            for (int f = 0; f < MAX_FLOWS; f++) begin
                if (m_armed[f] && (m_now - m_ts[f]) == longint'(TIMEOUT))
                    exp_q.push_back('{fid: f, seq: m_last[f], exp_now: m_now});
            end
            if (ack_val && exp_ack_rdy) begin
                if (m_seq_ge(ack_num, m_end[ack_flowid])) begin
                    m_armed[ack_flowid] = 1'b0;
                end else if (m_armed[ack_flowid] && ack_num != m_last[ack_flowid] &&
                             m_seq_ge(ack_num, m_last[ack_flowid])) begin
                    m_ts[ack_flowid] = m_now;
                end
                if (m_seq_ge(ack_num, m_last[ack_flowid])) m_last[ack_flowid] = ack_num;
            end
            if (arm_val && exp_arm_rdy) begin
                if (!m_armed[arm_flowid]) begin
                    m_armed[arm_flowid] = 1'b1;
                    m_ts[arm_flowid]    = m_now;
                end
                m_end[arm_flowid] = arm_end_seq;
            end
            if (rt_req_val === 1'b1 && rt_req_rdy) m_ts[rt_req_flowid] = m_now;
            m_now++;
        end
        m_rst_prev = !rst_n;
        if (!rst_n) mvalid = 1'b1;
    end

    // Scheduler-side ready: held low, held high, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rt_req_rdy = 1'b0;
                1:       rt_req_rdy = 1'b1;
                default: rt_req_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int f, input logic [31:0] es);
        int n;
        n = 0;
        arm_val = 1'b1;
        arm_flowid = 3'(f);
        arm_end_seq = es;
        @(negedge clk);
        while (!arm_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!arm_rdy) check_true("arm_handshake_timeout", 1'b0, longint'(n));
        @(posedge clk);
        #1;
        arm_val = 1'b0;
    endtask

    task automatic do_ack(input int f, input logic [31:0] num);
        int n;
        n = 0;
        ack_val = 1'b1;
        ack_flowid = 3'(f);
        ack_num = num;
        @(negedge clk);
        while (!ack_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ack_rdy) check_true("ack_handshake_timeout", 1'b0, longint'(n));
        @(posedge clk);
        #1;
        ack_val = 1'b0;
    endtask

    task automatic wait_req(input string name, input int unsigned target, input int budget);
        int n;
        n = 0;
        while (req_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check_true(name, req_count >= target, longint'(req_count));
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned     base_cnt;
        longint unsigned t_arm;
        logic [31:0]     base [MAX_FLOWS];
        longint unsigned t_start;
        int              f;

        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Lone armed flow: request, hold stable under back-pressure, periodic repeat.
        rdy_mode = 0;
        lat_bound = MAX_FLOWS;
        base_cnt = req_count;
        do_arm(2, 32'd1000);
        wait_req("t1_first_req", base_cnt + 1, 120);
        check("t1_fid", 64'(last_req_fid), 64'd2);
        check("t1_seq", 64'(last_req_seq), 64'd0);
        tick(5);
        rdy_mode = 1;
        wait_req("t1_second_req", base_cnt + 2, 140);
        do_ack(2, 32'd1000);
        tick(10);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Full ACK disarms the flow.
        base_cnt = req_count;
        do_arm(1, 32'd500);
        tick(59);
        do_ack(1, 32'd500);
        tick(300);
        check("t2_no_req", 64'(req_count - base_cnt), 64'd0);

        // Partial ACK restarts, duplicate does not.
        base_cnt = req_count;
        do_arm(3, 32'd800);
        t_arm = m_now;
        tick(59);
        do_ack(3, 32'd400);
        tick(18);
        do_ack(3, 32'd400);
        wait_req("t3_req", base_cnt + 1, 150);
        check_true("t3_req_time", (last_req_now - t_arm) >= 158 && (last_req_now - t_arm) <= 170,
                   longint'(last_req_now - t_arm));
        check("t3_fid", 64'(last_req_fid), 64'd3);
        check("t3_seq", 64'(last_req_seq), 64'd400);
        do_ack(3, 32'd800);
        tick(10);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Sequence-number wrap: step last_ack to 0xFFFF_FF00, then compares across zero.
        do_ack(5, 32'h7FFF_FFFF);
        do_ack(5, 32'hFFFF_FF00);
        base_cnt = req_count;
        do_arm(5, 32'h0000_0100);
        t_arm = m_now;
        tick(49);
        do_ack(5, 32'h0000_0010);
        wait_req("t4_req", base_cnt + 1, 150);
        check_true("t4_req_time", (last_req_now - t_arm) >= 148 && (last_req_now - t_arm) <= 160,
                   longint'(last_req_now - t_arm));
        check("t4_seq", 64'(last_req_seq), 64'h10);
        do_ack(5, 32'h0000_0100);
        tick(150);
        check("t4_disarmed", 64'(req_count - base_cnt), 64'd1);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Same-cycle ACK and arm on one flow: ACK applied, arm deferred one cycle.
        base_cnt = req_count;
        do_arm(4, 32'd200);
        arm_val = 1'b1; arm_flowid = 3'd4; arm_end_seq = 32'd400;
        ack_val = 1'b1; ack_flowid = 3'd4; ack_num = 32'd200;
        @(negedge clk);
        check("t5_arm_blocked", 64'(arm_rdy), 64'd0);
        check("t5_ack_ready", 64'(ack_rdy), 64'd1);
        tick(1);
        ack_val = 1'b0;
        @(negedge clk);
        check("t5_arm_ready", 64'(arm_rdy), 64'd1);
        tick(1);
        arm_val = 1'b0;
        wait_req("t5_req", base_cnt + 1, 130);
        check("t5_fid", 64'(last_req_fid), 64'd4);
        check("t5_seq", 64'(last_req_seq), 64'd200);
        do_ack(4, 32'd400);
        tick(10);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset while a request is presented.
        rdy_mode = 0;
        base_cnt = req_count;
        do_arm(0, 32'd50);
        do_arm(6, 32'd60);
        wait_req("t6_req", base_cnt + 1, 150);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("t6_val_cleared", 64'(rt_req_val), 64'd0);
        tick(1);
        rst_n = 1'b1;
        base_cnt = req_count;
        tick(300);
        check("t6_no_req_after_reset", 64'(req_count - base_cnt), 64'd0);
        rdy_mode = 1;

        // Randomized rounds: random arms/ACKs early, then let timers expire.
        for (int r = 0; r < 8; r++) begin
            rdy_mode = 2;
            lat_bound = 64;
            t_start = m_now;
            for (int k = 0; k < MAX_FLOWS; k++) begin
                base[k] = $urandom;
                if ($urandom_range(0, 1) == 1) do_arm(k, base[k] + 32'd1000);
            end
            for (int k = 0; k < 6; k++) begin
                f = int'($urandom_range(0, MAX_FLOWS - 1));
                case ($urandom_range(0, 3))
                    0: do_arm(f, base[f] + 32'd1000);
                    1: do_ack(f, base[f] + 32'($urandom_range(0, 1000)));
                    2: do_ack(f, base[f] + 32'($urandom_range(0, 400)));
                    default: do_arm(f, base[f] + 32'd1000 + 32'($urandom_range(0, 200)));
                endcase
            end
            while (m_now - t_start < 180) tick(1);
            rdy_mode = 1;
            for (int k = 0; k < MAX_FLOWS; k++) do_ack(k, base[k] + 32'd1300);
            tick(12);
            check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
